// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmit and receive halves:
// FSM state encoding, the oversampling ratio, and the default frame shape.
// -----------------------------------------------------------------------------
package uart_pkg;

  // s_tick pulses per bit period.
  localparam int OVERSAMPLE  = 16;

  // Default frame shape: 8 data bits, 1 stop bit.
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // PARITY is reachable only in builds that define UART_TX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_if
// Host-side byte handshake of the UART transmitter.
//   tx_start     : host request to send din (valid)
//   din          : byte to send, sampled only on acceptance
//   tx_ready     : transmitter idle and able to accept tx_start
//   tx_done_tick : one-cycle pulse when a frame's stop period completes
// Modports: master = host side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
);

  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_ready;
  logic            tx_done_tick;

  modport master (output tx_start, din, input  tx_ready, tx_done_tick);
  modport slave  (input  tx_start, din, output tx_ready, tx_done_tick);

endinterface

// File: rtl/uart_transmitter_datapath.sv
// -----------------------------------------------------------------------------
// uart_transmitter_datapath
// Counters and shift register of the UART transmitter; no sequencing of its own.
// Optional feature macro: UART_TX_PARITY_EN (adds the latched parity bit).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   din_i                 : byte to load
//   load_i / shift_i      : load din_i / shift right by one (load wins)
//   tick_en_i, tick_clr_i : tick counter increment / clear (clear wins)
//   bit_en_i, bit_clr_i   : bit counter increment / clear (clear wins)
//   data_o                : shift register bits [1:0] (current and next LSB)
//   s15_o                 : tick count is at the last tick of a bit period
//   stop_last_o           : tick count is at the last tick of the stop period
//   bit_last_o            : bit counter is on the last data bit
//   parity_o              : even parity of the loaded byte (parity builds only)
// -----------------------------------------------------------------------------
module uart_transmitter_datapath
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DBIT-1:0] din_i,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic            tick_en_i,
  input  logic            tick_clr_i,
  input  logic            bit_en_i,
  input  logic            bit_clr_i,
  output logic [1:0]      data_o,
  output logic            s15_o,
  output logic            stop_last_o,
  output logic            bit_last_o
`ifdef UART_TX_PARITY_EN
  ,
  output logic            parity_o
`endif
);

  logic [DBIT-1:0] shreg_q, shreg_d;
  // Bits [3:0] form the per-bit tick count; bit 4 is needed only so STOP can
  // run to SB_TICK values up to 32. Outside STOP the count is cleared at 15.
  logic [4:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;

  // NOTE: every signal gets a default before any condition so this block
  // stays purely combinational instead of inferring latches.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i)       shreg_d = din_i;
    else if (shift_i) shreg_d = {1'b0, shreg_q[DBIT-1:1]};

    tick_d = tick_q;
    if (tick_clr_i)     tick_d = '0;
    else if (tick_en_i) tick_d = tick_q + 5'd1;

    bit_d = bit_q;
    if (bit_clr_i)     bit_d = '0;
    else if (bit_en_i) bit_d = bit_q + 3'd1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values. The shift register is reset as well as the
  // control state: it is small, and a known value keeps tx deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from din at acceptance, so later shifts cannot disturb it.
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_q <= 1'b0;
    else if (load_i) parity_q <= ^din_i;
  end

  assign parity_o = parity_q;
`endif

  assign data_o      = shreg_q[1:0];
  assign s15_o       = (tick_q[3:0] == 4'(OVERSAMPLE - 1));
  assign stop_last_o = (tick_q == 5'(SB_TICK - 1));
  assign bit_last_o  = (bit_q == 3'(DBIT - 1));

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises one byte per accepted request: start bit, DBIT data bits LSB
// first, optional even parity bit, then SB_TICK s_ticks of stop level.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s_tick     : single-cycle pulse at 16x the baud rate
//   host       : uart_transmitter_if.slave (tx_start, din, tx_ready, tx_done_tick)
//   tx         : serial line, idle high; registered
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tick,
  uart_transmitter_if.slave     host,
  output logic                  tx
);

  uart_state_e state_q, state_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic        accept;
  logic        load, shift, tick_en, tick_clr, bit_en, bit_clr;
  logic [1:0]  data;
  logic        s15, stop_last, bit_last;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  uart_transmitter_datapath #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_i       (host.din),
    .load_i      (load),
    .shift_i     (shift),
    .tick_en_i   (tick_en),
    .tick_clr_i  (tick_clr),
    .bit_en_i    (bit_en),
    .bit_clr_i   (bit_clr),
    .data_o      (data),
    .s15_o       (s15),
    .stop_last_o (stop_last),
    .bit_last_o  (bit_last)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_o    (parity)
`endif
  );

  assign accept = host.tx_start & ready_q;

  // tx, tx_ready and tx_done_tick are computed here as next-state values and
  // registered, so tx never has a combinational path from any input.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    tick_en  = 1'b0;
    tick_clr = 1'b0;
    bit_en   = 1'b0;
    bit_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        // Clearing on acceptance also discards an s_tick in that same cycle.
        if (accept) begin
          state_d  = START;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
          load     = 1'b1;
          tick_clr = 1'b1;
          bit_clr  = 1'b1;
        end
      end

      START: begin
        tick_en = s_tick;
        if (s_tick && s15) begin
          tick_clr = 1'b1;
          state_d  = DATA;
          tx_d     = data[0];
        end
      end

      DATA: begin
        tick_en = s_tick;
        if (s_tick && s15) begin
          tick_clr = 1'b1;
          shift    = 1'b1;
          if (bit_last) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_en = 1'b1;
            // The register shifts on this same edge, so the next bit on the
            // line is the one currently one position above the LSB.
            tx_d   = data[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tick_en = s_tick;
        if (s_tick && s15) begin
          tick_clr = 1'b1;
          state_d  = STOP;
          tx_d     = 1'b1;
        end
      end
`endif

      STOP: begin
        tick_en = s_tick;
        if (s_tick && stop_last) begin
          tick_clr = 1'b1;
          state_d  = IDLE;
          tx_d     = 1'b1;
          ready_d  = 1'b1;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx                = tx_q;
  assign host.tx_ready     = ready_q;
  assign host.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench for uart_transmitter (DBIT=8, SB_TICK=16, s_tick every
// 4 clk, so one bit period is 64 clk). Frames are sampled mid-bit and compared
// with hand-computed frame words: bit i of a frame word is the i-th level on
// tx (start bit first). Builds with or without UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int          NB   = 11;
  localparam logic [10:0] F_00 = 11'h400;  // {stop, p=0, 8'h00, start}
  localparam logic [10:0] F_FF = 11'h5FE;  // p=0
  localparam logic [10:0] F_81 = 11'h502;  // p=0
  localparam logic [10:0] F_55 = 11'h4AA;  // p=0
  localparam logic [10:0] F_A5 = 11'h54A;  // p=0
`else
  localparam int          NB   = 10;
  localparam logic [10:0] F_00 = 11'h200;  // {stop, 8'h00, start}
  localparam logic [10:0] F_FF = 11'h3FE;
  localparam logic [10:0] F_81 = 11'h302;
  localparam logic [10:0] F_55 = 11'h2AA;
  localparam logic [10:0] F_A5 = 11'h34A;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic s_tick = 1'b0;
  logic tx;

  uart_transmitter_if #(.DBIT(8)) bus ();

  uart_transmitter #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_tick (s_tick),
    .host   (bus),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  // s_tick generator: one pulse every 4 clk, gated by tick_run.
  bit tick_run  = 1'b1;
  int tick_div  = 0;
  int tick_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      s_tick   = tick_run && (tick_div == 0);
    end
  end

  always @(posedge clk) if (s_tick) tick_seen++;

  // Done-pulse monitor.
  int done_cnt = 0;
  always @(negedge clk) if (bus.tx_done_tick === 1'b1) done_cnt++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_low(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, " start timeout"}, 32'd0, 32'd1);
  endtask

  // Samples frame bits first..NB-1, starting near the beginning of bit 'first'.
  task automatic expect_frame(input string name, input logic [10:0] exp, input int first);
    bit ok;
    if (first == 0) begin
      wait_tx_low(name, ok);
      if (!ok) return;
    end
    clocks(31);
    for (int i = first; i < NB; i++) begin
      if (i != first) clocks(64);
      check($sformatf("%s bit%0d", name, i), 32'(tx), 32'(exp[i]));
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx_done_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) check({name, " ready with done"}, 32'(bus.tx_ready), 32'd1);
  endtask

  // Presents d with tx_start until accepted, then drops tx_start and scrambles din.
  task automatic send(input string name, input logic [7:0] d);
    bit acc = 1'b0;
    bus.din      = d;
    bus.tx_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_ready === 1'b0) begin
        acc = 1'b1;
        break;
      end
    end
    bus.tx_start = 1'b0;
    bus.din      = ~d;
    check({name, " accepted"}, 32'(acc), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  din;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  d0;
    int  cnt;
    int  t0;
    bit  ok;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{"frame 07", 8'h07, 11'h60E};  // three ones -> parity 1
    vecs[1] = '{"frame 03", 8'h03, 11'h406};  // two ones   -> parity 0
    vecs[2] = '{"frame A5", 8'hA5, F_A5};
`else
    vecs[0] = '{"frame A5", 8'hA5, 11'h34A};  // 0,1,0,1,0,0,1,0,1,1
    vecs[1] = '{"frame 3C", 8'h3C, 11'h278};
    vecs[2] = '{"frame 0F", 8'h0F, 11'h21E};
`endif

    bus.tx_start = 1'b0;
    bus.din      = 8'h00;
    rst_n        = 1'b0;
    clocks(3);
    check("reset tx", 32'(tx), 32'd1);
    check("reset tx_ready", 32'(bus.tx_ready), 32'd1);
    check("reset tx_done_tick", 32'(bus.tx_done_tick), 32'd0);
    rst_n = 1'b1;
    clocks(10);
    check("idle tx", 32'(tx), 32'd1);

    // Table-driven single frames.
    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      send(vecs[v].name, vecs[v].din);
      expect_frame(vecs[v].name, vecs[v].frame, 0);
      wait_done(vecs[v].name);
      clocks(20);
      check({vecs[v].name, " one done pulse"}, 32'(done_cnt - d0), 32'd1);
    end

    // Back-to-back: tx_start held high across two frames.
    d0 = done_cnt;
    bus.din      = 8'h00;
    bus.tx_start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_ready === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b first accepted", 32'(ok), 32'd1);
    bus.din = 8'hFF;
    expect_frame("b2b first", F_00, 0);
    wait_done("b2b first");
    @(negedge clk);
    check("b2b start 1 clk after done", 32'(tx), 32'd0);
    check("b2b second accepted", 32'(bus.tx_ready), 32'd0);
    bus.tx_start = 1'b0;
    expect_frame("b2b second", F_FF, 0);
    wait_done("b2b second");
    clocks(20);
    check("b2b two done pulses", 32'(done_cnt - d0), 32'd2);

    // Busy-ignore: a request mid-frame must be dropped.
    d0 = done_cnt;
    send("busy 81", 8'h81);
    fork
      expect_frame("busy 81", F_81, 0);
      begin
        clocks(300);
        bus.din      = 8'h3C;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    wait_done("busy 81");
    cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("busy 3C never sent", 32'(cnt), 32'd0);
    check("busy one done pulse", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of data bit 3 of 8'h55 (a 0 on the line).
    d0 = done_cnt;
    send("rst 55", 8'h55);
    wait_tx_low("rst 55", ok);
    clocks(31 + 64 * 4);
    check("rst tx before reset", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("rst tx async high", 32'(tx), 32'd1);
    clocks(3);
    rst_n = 1'b1;
    clocks(1);
    check("rst tx_ready after release", 32'(bus.tx_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("rst line stays idle", 32'(cnt), 32'd0);
    check("rst no done pulse", 32'(done_cnt - d0), 32'd0);
    send("rst clean 55", 8'h55);
    expect_frame("rst clean 55", F_55, 0);
    wait_done("rst clean 55");

    // Stall: s_tick stops for 200 clk during the start bit.
    send("stall A5", 8'hA5);
    wait_tx_low("stall A5", ok);
    t0 = tick_seen;
    clocks(30);
    tick_run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b0) cnt++;
    end
    check("stall tx held low", 32'(cnt), 32'd0);
    tick_run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("stall start bit resumes", 32'(ok), 32'd1);
    check("stall start bit ticks", 32'(tick_seen - t0), 32'd16);
    expect_frame("stall A5", F_A5, 1);
    wait_done("stall A5");

    clocks(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
